// File: rtl/muldiv_stall_ctrl.sv
// Stall controller for a multi-cycle mul/div unit sitting in EX: launches the unit,
// holds the front of the pipeline for the op's latency and flags the write-back cycle.
module muldiv_stall_ctrl #(
  parameter int unsigned MUL_CYCLES   = 2,
  parameter int unsigned DIV_CYCLES   = 32,
  parameter int unsigned WIDTH_SOURCE = 5
) (
  input  logic                    CLK,
  input  logic                    rst,
  input  logic                    EX_MulDiv_Valid,
  input  logic                    EX_Is_Div,
  input  logic                    EX_Div_By_Zero,
  input  logic [WIDTH_SOURCE-1:0] EX_rd,
  input  logic                    Flush,
  output logic                    Unit_Start,
  output logic                    Result_Valid,
  output logic                    PC_Stall,
  output logic                    IF_ID_Stall,
  output logic                    ID_EX_Stall,
  output logic                    EX_MEM_Bubble,
  output logic                    Busy,
  output logic [WIDTH_SOURCE-1:0] Busy_rd
);

  localparam int unsigned CntW = $clog2(DIV_CYCLES + 1);
  localparam logic [CntW-1:0] MulLoad = CntW'(MUL_CYCLES - 1);
  localparam logic [CntW-1:0] DivLoad = CntW'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [WIDTH_SOURCE-1:0] busy_rd_q, busy_rd_d;
  logic                    start, stall, res_valid, single;
  logic [CntW-1:0]         load;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_rd_d = busy_rd_q;
    start     = 1'b0;
    stall     = 1'b0;
    res_valid = 1'b0;
    // A divide by zero resolves in one cycle regardless of DIV_CYCLES.
    single    = EX_Is_Div ? (EX_Div_By_Zero || (DIV_CYCLES == 1)) : (MUL_CYCLES == 1);
    load      = EX_Is_Div ? DivLoad : MulLoad;
    unique case (state_q)
      StIdle: begin
        if (EX_MulDiv_Valid && !Flush) begin
          start     = 1'b1;
          stall     = 1'b1;
          busy_rd_d = EX_rd;
          if (single) begin
            state_d = StDone;
            cnt_d   = '0;
          end else begin
            state_d = StRun;
            cnt_d   = load;
          end
        end
      end
      StRun: begin
        if (Flush) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          stall = 1'b1;
          if (cnt_q <= CntW'(1)) begin
            state_d = StDone;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
      end
      StDone: begin
        state_d   = StIdle;
        res_valid = !Flush;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      busy_rd_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_rd_q <= busy_rd_d;
    end
  end

  // Combinational outputs are gated so they read 0 for the whole reset window.
  assign Unit_Start    = start & ~rst;
  assign Result_Valid  = res_valid & ~rst;
  assign PC_Stall      = stall & ~rst;
  assign IF_ID_Stall   = stall & ~rst;
  assign ID_EX_Stall   = stall & ~rst;
  assign EX_MEM_Bubble = stall & ~rst;
  assign Busy          = (state_q != StIdle);
  assign Busy_rd       = busy_rd_q;

endmodule

// File: tb/tb_muldiv_stall_ctrl.sv
// Randomized and directed bench for muldiv_stall_ctrl, checked against a timeline model
// of each op (age since issue versus its latency N).
module tb_muldiv_stall_ctrl;

  localparam int MulN = 2;
  localparam int DivN = 32;

  logic       CLK = 1'b0;
  logic       rst = 1'b1;
  logic       EX_MulDiv_Valid = 1'b0, EX_Is_Div = 1'b0, EX_Div_By_Zero = 1'b0, Flush = 1'b0;
  logic [4:0] EX_rd = '0;
  logic       Unit_Start, Result_Valid, PC_Stall, IF_ID_Stall, ID_EX_Stall, EX_MEM_Bubble, Busy;
  logic [4:0] Busy_rd;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: an op in flight is described only by its age and total latency.
  bit         m_active = 1'b0;
  int         m_age    = 0;
  int         m_n      = 0;
  logic [4:0] m_rd     = '0;

  // Last observed outputs, for directed checks.
  logic       o_start, o_rv, o_stall, o_busy;
  logic [4:0] o_busy_rd;

  muldiv_stall_ctrl #(
    .MUL_CYCLES  (MulN),
    .DIV_CYCLES  (DivN),
    .WIDTH_SOURCE(5)
  ) dut (
    .CLK            (CLK),
    .rst            (rst),
    .EX_MulDiv_Valid(EX_MulDiv_Valid),
    .EX_Is_Div      (EX_Is_Div),
    .EX_Div_By_Zero (EX_Div_By_Zero),
    .EX_rd          (EX_rd),
    .Flush          (Flush),
    .Unit_Start     (Unit_Start),
    .Result_Valid   (Result_Valid),
    .PC_Stall       (PC_Stall),
    .IF_ID_Stall    (IF_ID_Stall),
    .ID_EX_Stall    (ID_EX_Stall),
    .EX_MEM_Bubble  (EX_MEM_Bubble),
    .Busy           (Busy),
    .Busy_rd        (Busy_rd)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Entered just after a rising edge; returns at the next rising edge.
  task automatic step(input logic v, input logic d, input logic z, input logic [4:0] rd,
                      input logic f);
    logic e_start, e_stall, e_rv, e_busy;
    #1;
    EX_MulDiv_Valid = v; EX_Is_Div = d; EX_Div_By_Zero = z; EX_rd = rd; Flush = f;
    #2;
    if (!m_active) begin
      e_start = v & ~f; e_stall = e_start; e_rv = 1'b0; e_busy = 1'b0;
    end else begin
      e_start = 1'b0; e_busy = 1'b1;
      if (m_age < m_n) begin e_stall = ~f; e_rv = 1'b0; end
      else begin e_stall = 1'b0; e_rv = ~f; end
    end
    chk("unit_start", Unit_Start, e_start);
    chk("result_valid", Result_Valid, e_rv);
    chk("pc_stall", PC_Stall, e_stall);
    chk("if_id_stall", IF_ID_Stall, e_stall);
    chk("id_ex_stall", ID_EX_Stall, e_stall);
    chk("ex_mem_bubble", EX_MEM_Bubble, e_stall);
    chk("busy", Busy, e_busy);
    chk("busy_rd", Busy_rd, m_rd);
    o_start = Unit_Start; o_rv = Result_Valid; o_stall = PC_Stall;
    o_busy = Busy; o_busy_rd = Busy_rd;
    if (!m_active) begin
      if (e_start) begin
        m_active = 1'b1; m_age = 1; m_rd = rd;
        m_n = d ? (z ? 1 : DivN) : MulN;
      end
    end else if (f || m_age >= m_n) begin
      m_active = 1'b0;
    end else begin
      m_age++;
    end
    @(posedge CLK);
  endtask

  // Asynchronous reset pulse starting mid-cycle; EX_MulDiv_Valid is low on release.
  task automatic reset_pulse(input logic v);
    #1;
    EX_MulDiv_Valid = v; Flush = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk("rst_unit_start", Unit_Start, 1'b0);
    chk("rst_result_valid", Result_Valid, 1'b0);
    chk("rst_stall", PC_Stall | IF_ID_Stall | ID_EX_Stall | EX_MEM_Bubble, 1'b0);
    chk("rst_busy", Busy, 1'b0);
    chk("rst_busy_rd", Busy_rd, 5'd0);
    m_active = 1'b0; m_rd = '0;
    @(posedge CLK);
    #1;
    EX_MulDiv_Valid = 1'b0;
    rst = 1'b0;
    @(posedge CLK);
  endtask

  // Issue one op with valid held high until Result_Valid is seen (bounded).
  task automatic run_op(input logic d, input logic z, input logic [4:0] rd,
                        output int rv_at, output int stalls);
    rv_at  = -1;
    stalls = 0;
    for (int t = 0; t < 60; t++) begin
      step(1'b1, d, z, rd, 1'b0);
      if (o_stall) stalls++;
      if (t == 0) chk("issue_start", o_start, 1'b1);
      if (t == 1) chk("latched_rd", o_busy_rd, rd);
      if (o_rv) begin
        rv_at = t;
        chk("no_stall_in_done", o_stall, 1'b0);
        break;
      end
    end
  endtask

  initial begin
    int rv_at, stalls, rv_cnt;
    logic v, d, z, f;
    logic [4:0] rd;

    // Reset state, with a valid op presented during reset.
    EX_MulDiv_Valid = 1'b1;
    #3;
    chk("reset_start", Unit_Start, 1'b0);
    chk("reset_stall", PC_Stall, 1'b0);
    chk("reset_busy", Busy, 1'b0);
    chk("reset_busy_rd", Busy_rd, 5'd0);
    EX_MulDiv_Valid = 1'b0;
    @(posedge CLK);
    #1 rst = 1'b0;
    @(posedge CLK);

    // MUL: stalls t0-t1, Result_Valid at t2.
    run_op(1'b0, 1'b0, 5'd7, rv_at, stalls);
    chk("mul_rv_at", rv_at, 2);
    chk("mul_stalls", stalls, 2);
    step(1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    chk("mul_rd_after", o_busy_rd, 5'd7);

    // DIV: 32 stall cycles, Result_Valid at t32.
    run_op(1'b1, 1'b0, 5'd19, rv_at, stalls);
    chk("div_rv_at", rv_at, 32);
    chk("div_stalls", stalls, 32);
    step(1'b0, 1'b0, 1'b0, 5'd0, 1'b0);

    // Divide by zero: stall at t0 only, Result_Valid at t1.
    run_op(1'b1, 1'b1, 5'd4, rv_at, stalls);
    chk("dbz_rv_at", rv_at, 1);
    chk("dbz_stalls", stalls, 1);
    step(1'b0, 1'b0, 1'b0, 5'd0, 1'b0);

    // Flush at t5 of a DIV.
    for (int t = 0; t < 5; t++) step(1'b1, 1'b1, 1'b0, 5'd11, 1'b0);
    step(1'b1, 1'b1, 1'b0, 5'd11, 1'b1);
    chk("flush_stall_drop", o_stall, 1'b0);
    step(1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    chk("flush_idle", o_busy, 1'b0);
    rv_cnt = 0;
    for (int t = 0; t < 35; t++) begin
      step(1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
      if (o_rv) rv_cnt++;
    end
    chk("flush_no_rv", rv_cnt, 0);

    // Flush in IDLE with valid: no issue.
    step(1'b1, 1'b0, 1'b0, 5'd3, 1'b1);
    chk("idle_flush_start", o_start, 1'b0);
    chk("idle_flush_stall", o_stall, 1'b0);

    // Back-to-back MUL then DIV.
    run_op(1'b0, 1'b0, 5'd9, rv_at, stalls);
    chk("b2b_mul_rv_at", rv_at, 2);
    run_op(1'b1, 1'b0, 5'd12, rv_at, stalls);
    chk("b2b_div_rv_at", rv_at, 32);
    step(1'b0, 1'b0, 1'b0, 5'd0, 1'b0);

    // Reset at t10 of a DIV, then a clean new issue.
    for (int t = 0; t < 10; t++) step(1'b1, 1'b1, 1'b0, 5'd21, 1'b0);
    reset_pulse(1'b1);
    step(1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    chk("post_rst_idle", o_busy, 1'b0);
    chk("post_rst_no_rv", o_rv, 1'b0);
    run_op(1'b1, 1'b0, 5'd22, rv_at, stalls);
    chk("post_rst_div_rv_at", rv_at, 32);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 999) < 4) begin
        reset_pulse($urandom_range(0, 1) == 1);
      end else begin
        v  = ($urandom_range(0, 9) < 7);
        d  = ($urandom_range(0, 9) < 4);
        z  = ($urandom_range(0, 9) < 2);
        f  = ($urandom_range(0, 99) < 4);
        rd = 5'($urandom_range(0, 31));
        step(v, d, z, rd, f);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_stall_ctrl.md
MULDIV_STALL_CTRL -- requirements
Module: muldiv_stall_ctrl

Interface
REQ-001 SHALL have parameter MUL_CYCLES, default 2, multiply latency in cycles (legal range 1..DIV_CYCLES).
REQ-002 SHALL have parameter DIV_CYCLES, default 32, divide/remainder latency in cycles (legal range at least 1).
REQ-003 SHALL have parameter WIDTH_SOURCE, default 5, register-index width.
REQ-004 SHALL have port CLK  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port EX_MulDiv_Valid  input  1  EX-stage instruction is an M-extension op.
REQ-007 SHALL have port EX_Is_Div  input  1  1 = div/rem, 0 = mul; sampled only at issue.
REQ-008 SHALL have port EX_Div_By_Zero  input  1  divisor is zero; sampled only at issue when EX_Is_Div=1.
REQ-009 SHALL have port EX_rd  input  WIDTH_SOURCE  destination register of the EX-stage op.
REQ-010 SHALL have port Flush  input  1  branch/exception flush of the EX stage.
REQ-011 SHALL have port Unit_Start  output  1  one-cycle pulse that launches the mul/div unit.
REQ-012 SHALL have port Result_Valid  output  1  one-cycle pulse indicating the unit result is final and is written back.
REQ-013 SHALL have port PC_Stall, IF_ID_Stall, ID_EX_Stall  output  1 each  hold PC and the pipeline registers.
REQ-014 SHALL have port EX_MEM_Bubble  output  1  insert a bubble into EX/MEM.
REQ-015 SHALL have port Busy  output  1  an op is in flight (state RUN or DONE).
REQ-016 SHALL have port Busy_rd  output  WIDTH_SOURCE  rd of the in-flight op, consumed by the forwarding and hazard logic.

Function
REQ-017 SHALL implement the FSM states IDLE, RUN and DONE, plus a down-counter CNT of width clog2(DIV_CYCLES+1).
REQ-018 SHALL define the issue condition as: state IDLE, EX_MulDiv_Valid=1 and Flush=0.
REQ-019 SHALL, in the issue cycle, drive Unit_Start=1, assert all four stall/bubble outputs combinationally, and latch EX_rd into Busy_rd.
REQ-020 SHALL choose the latency at issue: N = DIV_CYCLES when EX_Is_Div=1, otherwise MUL_CYCLES; N = 1 when EX_Is_Div=1 and EX_Div_By_Zero=1.
REQ-021 SHALL, at issue, go to DONE if N=1; otherwise go to RUN with CNT = N-1.
REQ-022 SHALL, in RUN, assert all stall/bubble outputs; go to DONE if CNT=1, else decrement CNT.
REQ-023 SHALL, in DONE, drive Result_Valid=1, deassert all stalls so the op leaves EX, and return to IDLE.
REQ-024 SHALL produce exactly N stall cycles per op (issue cycle t0 through t(N-1)) and Result_Valid at cycle tN.
REQ-025 SHALL NOT re-issue in DONE even though EX_MulDiv_Valid is still high; a back-to-back op issues in the following IDLE cycle.
REQ-026 SHALL, on Flush=1 in RUN or DONE, go to IDLE next edge, suppress Result_Valid, and deassert stalls in that cycle; Flush has priority over completion.
REQ-027 SHALL NOT issue when Flush=1 in IDLE: no Unit_Start, no stall.
REQ-028 SHALL drive Unit_Start and Result_Valid high for only one cycle each per op; Busy = (state != IDLE).
REQ-029 SHALL NOT let CNT wrap below 1 in RUN.
REQ-030 SHALL keep the Busy_rd value stable while Busy=1.

Reset
REQ-031 SHALL, while rst=1, asynchronously force state IDLE, CNT=0 and Busy_rd=0, with all outputs 0.
REQ-032 SHALL, on reset asserted mid-operation, abandon the op with no Result_Valid; after reset deasserts, the first issue requires a fresh EX_MulDiv_Valid.

Verification
REQ-033 SHALL cover: MUL issue with MUL_CYCLES=2 at t0 -> Unit_Start@t0, stalls@t0-t1, Result_Valid@t2, Busy_rd=EX_rd.
REQ-034 SHALL cover: DIV issue with DIV_CYCLES=32 -> stalls for 32 cycles, Result_Valid@t32, CNT never below 1.
REQ-035 SHALL cover: DIV with EX_Div_By_Zero=1 -> stall@t0 only, Result_Valid@t1.
REQ-036 SHALL cover: Flush at t5 of a DIV -> stalls drop @t5, IDLE@t6, no Result_Valid ever; Flush in IDLE with valid -> no Unit_Start.
REQ-037 SHALL cover: back-to-back MUL then DIV -> second Unit_Start exactly one cycle after the first Result_Valid, no stall in the DONE cycle.
REQ-038 SHALL cover: rst pulse at t10 of a DIV -> outputs 0 immediately (asynchronously), no Result_Valid, then a clean new issue.
